// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/issue controller.
package hazard_pkg;

  localparam int unsigned REG_W           = 4;
  localparam int unsigned CNT_W           = 4;
  localparam int unsigned VEC_LAT_DEFAULT = 4;

  typedef enum logic [0:0] {
    IDLE,
    VEC_RUN
  } vec_state_t;

endpackage

// File: rtl/vec_occupancy_timer.sv
// Occupancy timer for the shared fixed-latency vector unit: busy for VEC_LAT-1 cycles
// after each issue.
module vec_occupancy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned VEC_LAT = VEC_LAT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic issue,
  output logic busy
);

  vec_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          state_d = VEC_RUN;
          cnt_d   = CNT_W'(VEC_LAT - 1);
        end
      end
      VEC_RUN: begin
        // Runs to completion; flushes and redirects cannot cancel an issued op.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == VEC_RUN);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/issue controller: load-use, PC-write and vector-busy stalls plus redirects.
// Optional StallD performance counter enabled by defining HAZARD_PERF_EN.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned VEC_LAT = VEC_LAT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] RA1D,
  input  logic [REG_W-1:0] RA2D,
  input  logic [REG_W-1:0] WA3E,
  input  logic             MemtoRegE,
  input  logic             RegWriteE,
  input  logic             PCSrcD,
  input  logic             PCSrcE,
  input  logic             PCSrcM,
  input  logic             PCSrcW,
  input  logic             BranchTakenE,
  input  logic             VecOpD,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             VecIssueE,
  output logic             VecBusy,
  output logic [31:0]      StallCycles
);

  logic ldr_stall;
  logic pc_pend;
  logic redirect;
  logic vec_stall;
  logic timer_busy;

  assign ldr_stall = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign pc_pend   = PCSrcD | PCSrcE | PCSrcM;
  assign redirect  = BranchTakenE | PCSrcW;

  // The timer may still hold VEC_RUN during the reset cycle; hide it until the edge.
  assign VecBusy   = timer_busy & ~reset;
  assign vec_stall = VecOpD & VecBusy;

  assign StallD = (ldr_stall | vec_stall) & ~redirect & ~reset;
  assign StallF = (ldr_stall | vec_stall | pc_pend) & ~redirect & ~reset;
  assign FlushD = pc_pend | redirect | reset;
  assign FlushE = ldr_stall | vec_stall | BranchTakenE | reset;

  assign VecIssueE = VecOpD & ~timer_busy & ~ldr_stall & ~FlushD;

  vec_occupancy_timer #(
    .VEC_LAT (VEC_LAT)
  ) u_vec_timer (
    .clk   (clk),
    .reset (reset),
    .issue (VecIssueE),
    .busy  (timer_busy)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (StallD) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
`else
  assign StallCycles = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and issue controller for the scalar/vector pipeline. It sits beside the fetch, decode and execute stages and drives `StallF`, `StallD`, `FlushD` and `FlushE`. It also schedules the shared, fixed-latency vector unit, so only one vector instruction occupies it at a time. It resolves load-use stalls, PC-write-pending stalls, and branch/PC-write redirects.

## Interface
Parameters:
- `VEC_LAT`, default 4: vector unit occupancy in cycles per instruction; legal range 2..15.

Ports:
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high.
- `RA1D`, `RA2D` in 4: source register numbers of the instruction in decode.
- `WA3E` in 4: destination register of the instruction in execute.
- `MemtoRegE` in 1: the instruction in execute is a load.
- `RegWriteE` in 1: the instruction in execute writes the register file.
- `PCSrcD`, `PCSrcE`, `PCSrcM` in 1: an instruction writing the PC is in that stage.
- `PCSrcW` in 1: a PC write is committing this cycle.
- `BranchTakenE` in 1: a branch resolved taken in execute.
- `VecOpD` in 1: the decode instruction is a vector instruction.
- `StallF`, `StallD`, `FlushD`, `FlushE` out 1: pipeline controls.
- `VecIssueE` out 1: a vector instruction enters execute next edge.
- `VecBusy` out 1: the vector unit is occupied.
- `StallCycles` out 32: performance count of `StallD` cycles (see Configuration).

Clock/reset are fixed: one clock `clk`; `reset` is synchronous and active-high.

## Operation
Terms:
- `ldrStall = MemtoRegE & RegWriteE & (WA3E==RA1D | WA3E==RA2D)`
- `pcPend = PCSrcD | PCSrcE | PCSrcM`
- `redirect = BranchTakenE | PCSrcW`
- `vecStall = VecOpD & VecBusy`

Outputs (combinational from inputs and registered state):
- `StallD = (ldrStall | vecStall) & ~redirect`
- `StallF = (ldrStall | vecStall | pcPend) & ~redirect`
- `FlushD = pcPend | redirect`
- `FlushE = ldrStall | vecStall | BranchTakenE`
- Redirect has priority: stalls never block a PC redirect.

Vector FSM (states `IDLE`, `VEC_RUN`; 4-bit `cnt`):
- In `IDLE`, `VecBusy`=0.
  - Issue condition: `VecOpD & ~ldrStall & ~FlushD`.
  - On issue, `VecIssueE`=1, next state `VEC_RUN`, `cnt`<=`VEC_LAT-1`.
- In `VEC_RUN`, `VecBusy`=1 and `VecIssueE`=0. Each cycle `cnt` decrements.
  - If `cnt==1`, next state `IDLE`.
  - With `VEC_LAT==2`, `VEC_RUN` lasts exactly one cycle.
- Flushes and redirects never cancel an already-issued vector op; `VEC_RUN` runs to completion.
- A vector op flushed from decode (`FlushD`) does not issue.

## Timing
- Reset behaviour:
  - While `reset`=1: `FlushD`=`FlushE`=1; `StallF`, `StallD`, `VecIssueE`, `VecBusy` = 0.
  - Next state is `IDLE`, `cnt`=0, `StallCycles`=0.
  - Reset in the middle of `VEC_RUN` abandons the op.
- Issue spacing: issue at cycle t puts `VecBusy` high for cycles t+1..t+VEC_LAT-1. The earliest next issue is t+VEC_LAT.
- A vector op waiting in decode is stalled for exactly the remaining busy cycles, then issues in the first `IDLE` cycle.
- Simultaneous `ldrStall` and `vecStall`: a single stall occurs, and `FlushE` is asserted once per cycle.
- `BranchTakenE` with `vecStall`: no stall; decode is flushed and the vector op is discarded.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `StallCycles` increments by 1 every non-reset cycle with `StallD`=1.
  - Wraps from 0xFFFFFFFF to 0.
- `HAZARD_PERF_EN` undefined: the counter is not built and `StallCycles` is tied to 0. The port list is unchanged.

## Structure
- Package `hazard_pkg`:
  - FSM enum `vec_state_t` {`IDLE`, `VEC_RUN`}.
  - Register-number width constant (4).
  - Default `VEC_LAT`.
- Sub-module `vec_occupancy_timer`: holds the FSM and `cnt`. Inputs `issue`; outputs `busy`.
- `hazard_ctrl` contains the combinational hazard equations and the optional perf counter.

## Test plan
- Load-use: `MemtoRegE`=1, `RegWriteE`=1, `WA3E`=5, `RA1D`=5 → `StallF`=`StallD`=`FlushE`=1 for one cycle; `FlushD`=0.
- Back-to-back vector ops with `VEC_LAT`=4 and `VecOpD` held high: issue at t → `VecBusy` at t+1..t+3, `StallD`=1 on those cycles, second `VecIssueE` at t+4.
- PC write: `PCSrcD` pulse moving through D/E/M/W → `StallF`=1 and `FlushD`=1 for 3 cycles; at the W cycle `StallF`=0 and `FlushD`=1.
- `BranchTakenE`=1 during `VecBusy` with `VecOpD`=1 → `StallF`=`StallD`=0, `FlushD`=`FlushE`=1; no issue next cycle; `VEC_RUN` completes unchanged.
- Reset asserted at the second `VEC_RUN` cycle → next cycle `VecBusy`=0; a new `VecOpD` issues immediately after reset deasserts.
- With `HAZARD_PERF_EN`: 7 stall cycles → `StallCycles`=7. Without it: `StallCycles` stays 0.
